// File: rtl/cmp_pkg.sv
// Shared types for the compare monitor: alarm FSM states and the one-hot
// compare result carried from the comparator to the output register.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ALARM,
    RELEASE
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational magnitude compare of two WIDTH-bit operands.
// Signed mode flips the sign bit of both operands, which maps two's
// complement ordering onto unsigned ordering, so one comparator serves both.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_result_t      result
);

  localparam logic [WIDTH-1:0] SIGN_FLIP =
    (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  assign a_key = a ^ SIGN_FLIP;
  assign b_key = b ^ SIGN_FLIP;

  assign result.gt = (a_key > b_key);
  assign result.eq = (a_key == b_key);
  assign result.lt = (a_key < b_key);

endmodule

// File: rtl/compare_monitor.sv
// Compare monitor: registers a gt/eq/lt result for each accepted A/B pair
// behind a one-entry valid/ready output stage, and raises alarm after
// PERSIST consecutive A>B samples.
// Build option: define CMP_HYST_EN to add a RELEASE state so that alarm only
// drops after PERSIST consecutive non-gt samples.
module compare_monitor
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SIGNED  = 0,
  parameter int PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             alarm
);

  localparam int              CW      = $clog2(PERSIST + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(PERSIST);

  cmp_result_t   cur;
  logic          accept;
  cmp_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  cmp_core #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_core (
    .a     (A),
    .b     (B),
    .result(cur)
  );

  // One-entry output register: a new pair may enter whenever the slot is
  // empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Saturating increment so the counter can never wrap past PERSIST.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Output register: load on accept, empty after a transfer, hold otherwise.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values; async reset clears held data at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      {gt, eq, lt}   <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      {gt, eq, lt}   <= cur;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

  // Alarm FSM: advances on accepted samples only; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      alarm <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      alarm <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (cur.gt) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state <= ALARM;
              alarm <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (cur.gt) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state <= ALARM;
              alarm <= 1'b1;
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        ALARM: begin
          if (cur.gt) begin
            cnt <= CNT_MAX;
          end else begin
`ifdef CMP_HYST_EN
            if (CNT_MAX == CW'(1)) begin
              state <= IDLE;
              cnt   <= '0;
              alarm <= 1'b0;
            end else begin
              state <= RELEASE;
              cnt   <= CW'(1);
            end
`else
            state <= IDLE;
            cnt   <= '0;
            alarm <= 1'b0;
`endif
          end
        end
`ifdef CMP_HYST_EN
        RELEASE: begin
          if (cur.gt) begin
            state <= ALARM;
            cnt   <= CNT_MAX;
          end else if (cnt_inc == CNT_MAX) begin
            state <= IDLE;
            cnt   <= '0;
            alarm <= 1'b0;
          end else begin
            cnt   <= cnt_inc;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule
